regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_bank.sv | 41 ++++
 rtl/regfile.sv | 180 ++++++++++++++++++
 tb/tb_regfile.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, index type and read-FSM state encoding for the register file.
// Optional same-edge write forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int IDXW = $clog2(NREG);

    typedef logic [IDXW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/regfile_bank.sv
// One bank of NREG x XLEN registers with a single write port and two combinational reads.
// ZERO_X0 makes entry 0 hardwired to zero (integer bank).
module regfile_bank #(
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int NREG    = regfile_pkg::NREG,
    parameter bit ZERO_X0 = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_waddr,
    input  logic [XLEN-1:0]         i_wdata,
    input  logic [$clog2(NREG)-1:0] i_raddr1,
    input  logic [$clog2(NREG)-1:0] i_raddr2,
    output logic [XLEN-1:0]         o_rdata1,
    output logic [XLEN-1:0]         o_rdata2
);

    logic [XLEN-1:0] r_mem [NREG];
    logic            w_wr_allowed;

    assign w_wr_allowed = i_we && !(ZERO_X0 && (i_waddr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_allowed) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        o_rdata2 = r_mem[i_raddr2];
        if (ZERO_X0 && (i_raddr1 == '0)) o_rdata1 = '0;
        if (ZERO_X0 && (i_raddr2 == '0)) o_rdata2 = '0;
    end

endmodule

// File: rtl/regfile.sv
// Integer + float register file with per-register pending bits and a blocking operand-read FSM.
// Define REGFILE_BYPASS_EN to let a same-edge writeback release a waiting read and forward its data.
module regfile #(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_enable,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    input  logic                    rs1_f,
    input  logic                    rs2_f,
    output logic                    rd_done,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    output logic                    busy,
    input  logic                    rsv_enable,
    input  logic [$clog2(NREG)-1:0] rsv_reg,
    input  logic                    rsv_f,
    input  logic                    wenable,
    input  logic                    fmode,
    input  logic [$clog2(NREG)-1:0] wreg,
    input  logic [XLEN-1:0]         wdata
);

    import regfile_pkg::*;

    localparam int IW = $clog2(NREG);

    // state   | meaning
    // IDLE    | accepting a new read request
    // WAIT    | latched sources still pending, re-checked every edge
    // RESP    | rdata valid, rd_done high for this one cycle
    rd_state_t r_state;
    rd_state_t w_state_nxt;

    logic [IW-1:0]   r_rs1;
    logic [IW-1:0]   r_rs2;
    logic            r_rs1_f;
    logic            r_rs2_f;
    logic [NREG-1:0] r_pend_int;
    logic [NREG-1:0] r_pend_fp;
    logic [NREG-1:0] w_pend_int_nxt;
    logic [NREG-1:0] w_pend_fp_nxt;

    logic [IW-1:0]   w_src1;
    logic [IW-1:0]   w_src2;
    logic            w_src1_f;
    logic            w_src2_f;
    logic            w_pend1;
    logic            w_pend2;
    logic            w_ready;
    logic [XLEN-1:0] w_int_rd1;
    logic [XLEN-1:0] w_int_rd2;
    logic [XLEN-1:0] w_fp_rd1;
    logic [XLEN-1:0] w_fp_rd2;
    logic [XLEN-1:0] w_val1;
    logic [XLEN-1:0] w_val2;
    logic            w_load;

    regfile_bank #(.XLEN(XLEN), .NREG(NREG), .ZERO_X0(1'b1)) u_bank_int (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wenable && !fmode),
        .i_waddr  (wreg),
        .i_wdata  (wdata),
        .i_raddr1 (w_src1),
        .i_raddr2 (w_src2),
        .o_rdata1 (w_int_rd1),
        .o_rdata2 (w_int_rd2)
    );

    regfile_bank #(.XLEN(XLEN), .NREG(NREG), .ZERO_X0(1'b0)) u_bank_fp (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wenable && fmode),
        .i_waddr  (wreg),
        .i_wdata  (wdata),
        .i_raddr1 (w_src1),
        .i_raddr2 (w_src2),
        .o_rdata1 (w_fp_rd1),
        .o_rdata2 (w_fp_rd2)
    );

    // In IDLE the request is evaluated straight from the ports, afterwards from the latched copy.
    assign w_src1   = (r_state == ST_IDLE) ? rs1   : r_rs1;
    assign w_src2   = (r_state == ST_IDLE) ? rs2   : r_rs2;
    assign w_src1_f = (r_state == ST_IDLE) ? rs1_f : r_rs1_f;
    assign w_src2_f = (r_state == ST_IDLE) ? rs2_f : r_rs2_f;

`ifdef REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = wenable && (fmode == w_src1_f) && (wreg == w_src1) && (w_src1_f || (w_src1 != '0));
    assign w_hit2 = wenable && (fmode == w_src2_f) && (wreg == w_src2) && (w_src2_f || (w_src2 != '0));

    assign w_pend1 = (w_src1_f ? r_pend_fp[w_src1] : r_pend_int[w_src1]) && !w_hit1;
    assign w_pend2 = (w_src2_f ? r_pend_fp[w_src2] : r_pend_int[w_src2]) && !w_hit2;
    assign w_val1  = w_hit1 ? wdata : (w_src1_f ? w_fp_rd1 : w_int_rd1);
    assign w_val2  = w_hit2 ? wdata : (w_src2_f ? w_fp_rd2 : w_int_rd2);
`else
    assign w_pend1 = w_src1_f ? r_pend_fp[w_src1] : r_pend_int[w_src1];
    assign w_pend2 = w_src2_f ? r_pend_fp[w_src2] : r_pend_int[w_src2];
    assign w_val1  = w_src1_f ? w_fp_rd1 : w_int_rd1;
    assign w_val2  = w_src2_f ? w_fp_rd2 : w_int_rd2;
`endif

    assign w_ready = !w_pend1 && !w_pend2;

    // Reservation is applied after the clear so a same-edge set and clear leaves the bit set.
    always_comb begin
        w_pend_int_nxt = r_pend_int;
        w_pend_fp_nxt  = r_pend_fp;
        if (wenable && !fmode)    w_pend_int_nxt[wreg]    = 1'b0;
        if (wenable && fmode)     w_pend_fp_nxt[wreg]     = 1'b0;
        if (rsv_enable && !rsv_f) w_pend_int_nxt[rsv_reg] = 1'b1;
        if (rsv_enable && rsv_f)  w_pend_fp_nxt[rsv_reg]  = 1'b1;
        w_pend_int_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_int <= '0;
            r_pend_fp  <= '0;
        end else begin
            r_pend_int <= w_pend_int_nxt;
            r_pend_fp  <= w_pend_fp_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (rd_enable) w_state_nxt = w_ready ? ST_RESP : ST_WAIT;
            ST_WAIT: if (w_ready)   w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_done = (r_state == ST_RESP);
        busy    = (r_state == ST_WAIT) || (r_state == ST_RESP);
    end

    assign w_load = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rs1_f <= 1'b0;
            r_rs2_f <= 1'b0;
            rdata1  <= '0;
            rdata2  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && rd_enable) begin
                r_rs1   <= rs1;
                r_rs2   <= rs2;
                r_rs1_f <= rs1_f;
                r_rs2_f <= rs2_f;
            end
            if (w_load) begin
                rdata1 <= w_val1;
                rdata2 <= w_val2;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: an abstract register/pending model checked every cycle,
// plus literal checks of the documented scenarios. Honours REGFILE_BYPASS_EN.
module tb_regfile;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rd_enable = 1'b0;
    logic [4:0]      rs1 = '0, rs2 = '0;
    logic            rs1_f = 1'b0, rs2_f = 1'b0;
    logic            rd_done;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            busy;
    logic            rsv_enable = 1'b0;
    logic [4:0]      rsv_reg = '0;
    logic            rsv_f = 1'b0;
    logic            wenable = 1'b0;
    logic            fmode = 1'b0;
    logic [4:0]      wreg = '0;
    logic [XLEN-1:0] wdata = '0;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .rd_enable(rd_enable),
        .rs1(rs1), .rs2(rs2), .rs1_f(rs1_f), .rs2_f(rs2_f),
        .rd_done(rd_done), .rdata1(rdata1), .rdata2(rdata2), .busy(busy),
        .rsv_enable(rsv_enable), .rsv_reg(rsv_reg), .rsv_f(rsv_f),
        .wenable(wenable), .fmode(fmode), .wreg(wreg), .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register contents, pending bits, and one outstanding request.
    logic [31:0] m_int [NREG];
    logic [31:0] m_fp  [NREG];
    bit          m_pi  [NREG];
    bit          m_pf  [NREG];
    bit          m_out, m_done;
    logic [4:0]  m_a, m_b;
    bit          m_af, m_bf;
    logic [31:0] m_r1, m_r2;

    function automatic bit m_hit(input logic [4:0] idx, input bit f);
        return wenable && (fmode == f) && (wreg == idx) && (f || idx != 0);
    endfunction

    function automatic bit m_pending(input logic [4:0] idx, input bit f);
        bit p;
        p = f ? m_pf[idx] : (idx != 0 && m_pi[idx]);
        if (BYP && m_hit(idx, f)) p = 0;
        return p;
    endfunction

    function automatic logic [31:0] m_value(input logic [4:0] idx, input bit f);
        if (BYP && m_hit(idx, f)) return wdata;
        if (f) return m_fp[idx];
        return (idx == 0) ? 32'h0 : m_int[idx];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_int[i] = '0; m_fp[i] = '0; m_pi[i] = 0; m_pf[i] = 0;
            end
            m_out = 0; m_done = 0; m_r1 = '0; m_r2 = '0;
        end else begin
            if (m_done) begin
                m_done = 0;
            end else begin
                if (!m_out && rd_enable) begin
                    m_out = 1; m_a = rs1; m_b = rs2; m_af = rs1_f; m_bf = rs2_f;
                end
                if (m_out && !m_pending(m_a, m_af) && !m_pending(m_b, m_bf)) begin
                    m_r1 = m_value(m_a, m_af);
                    m_r2 = m_value(m_b, m_bf);
                    m_out = 0; m_done = 1;
                end
            end
            if (wenable) begin
                if (fmode) begin m_fp[wreg] = wdata; m_pf[wreg] = 0; end
                else if (wreg != 0) begin m_int[wreg] = wdata; m_pi[wreg] = 0; end
            end
            if (rsv_enable) begin
                if (rsv_f) m_pf[rsv_reg] = 1;
                else if (rsv_reg != 0) m_pi[rsv_reg] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_rd_done", {31'b0, rd_done}, {31'b0, m_done});
            check("cyc_busy", {31'b0, busy}, {31'b0, m_out | m_done});
            check("cyc_rdata1", rdata1, m_r1);
            check("cyc_rdata2", rdata2, m_r2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rd_enable = 0; rsv_enable = 0; wenable = 0;
    endtask

    task automatic do_write(input bit f, input logic [4:0] r, input logic [31:0] d);
        wenable = 1; fmode = f; wreg = r; wdata = d;
        cyc();
        wenable = 0;
    endtask

    task automatic do_rsv(input bit f, input logic [4:0] r);
        rsv_enable = 1; rsv_f = f; rsv_reg = r;
        cyc();
        rsv_enable = 0;
    endtask

    task automatic issue_read(input logic [4:0] a, input bit af, input logic [4:0] b, input bit bf);
        rd_enable = 1; rs1 = a; rs1_f = af; rs2 = b; rs2_f = bf;
        cyc();
        rd_enable = 0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n;
        n = 0;
        while (!rd_done && n < maxc) begin
            cyc();
            n++;
        end
        if (!rd_done) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        int cnt;
        rst = 1;
        cyc(); cyc();
        check("rst_rd_done", {31'b0, rd_done}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        rst = 0;
        cyc();

        do_write(0, 5'd5, 32'h0000_1234);
        issue_read(5'd5, 0, 5'd0, 0);
        check("x5_latency_done", {31'b0, rd_done}, 32'h1);
        check("x5_rdata1", rdata1, 32'h0000_1234);
        check("x5_rdata2", rdata2, 32'h0);
        cyc();
        check("x5_done_pulse", {31'b0, rd_done}, 32'h0);

        do_write(0, 5'd0, 32'hFFFF_FFFF);
        issue_read(5'd0, 0, 5'd5, 0);
        check("x0_reads_zero", rdata1, 32'h0);
        cyc();
        do_write(1, 5'd0, 32'hFFFF_FFFF);
        issue_read(5'd0, 1, 5'd0, 0);
        check("f0_writable", rdata1, 32'hFFFF_FFFF);
        cyc();

        cnt = 0;
        rd_enable = 1; rs1 = 5'd5; rs1_f = 0; rs2 = 5'd0; rs2_f = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (rd_done) cnt++;
        end
        rd_enable = 0;
        check("back_to_back_pulses", cnt, 32'd2);
        cyc(); cyc();

        do_rsv(0, 5'd7);
        issue_read(5'd7, 0, 5'd0, 0);
        for (int i = 0; i < 5; i++) begin
            check("x7_wait_busy", {31'b0, busy}, 32'h1);
            check("x7_wait_no_done", {31'b0, rd_done}, 32'h0);
            cyc();
        end
        do_write(0, 5'd7, 32'hA5A5_A5A5);
        if (!BYP) begin
            check("x7_extra_wait", {31'b0, rd_done}, 32'h0);
            cyc();
        end
        check("x7_done", {31'b0, rd_done}, 32'h1);
        check("x7_rdata1", rdata1, 32'hA5A5_A5A5);
        cyc(); cyc();

        rsv_enable = 1; rsv_f = 1; rsv_reg = 5'd3;
        do_write(1, 5'd3, 32'h3333_3333);
        rsv_enable = 0;
        issue_read(5'd3, 1, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            check("f3_still_pending", {31'b0, busy & ~rd_done}, 32'h1);
            cyc();
        end
        do_write(1, 5'd3, 32'h4444_4444);
        wait_done("f3", 4);
        check("f3_rdata1", rdata1, 32'h4444_4444);
        cyc(); cyc();

        do_rsv(0, 5'd9);
        issue_read(5'd9, 0, 5'd5, 0);
        issue_read(5'd5, 0, 5'd0, 0);
        check("ignore_busy", {31'b0, busy}, 32'h1);
        check("ignore_no_done", {31'b0, rd_done}, 32'h0);
        cyc();
        do_write(0, 5'd9, 32'h0000_0099);
        wait_done("orig_req", 4);
        check("orig_rdata1", rdata1, 32'h0000_0099);
        check("orig_rdata2", rdata2, 32'h0000_1234);
        cyc(); cyc();

        do_rsv(0, 5'd11);
        issue_read(5'd11, 0, 5'd5, 0);
        check("pre_rst_busy", {31'b0, busy}, 32'h1);
        rst = 1;
        #1;
        check("async_rst_busy", {31'b0, busy}, 32'h0);
        check("async_rst_done", {31'b0, rd_done}, 32'h0);
        check("async_rst_rdata2", rdata2, 32'h0);
        cyc();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("post_rst_no_done", {31'b0, rd_done}, 32'h0);
        end
        issue_read(5'd5, 0, 5'd11, 0);
        check("post_rst_done", {31'b0, rd_done}, 32'h1);
        check("post_rst_x5_zero", rdata1, 32'h0);
        cyc(); cyc();

        quiet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
